// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and display-path types for the VGA timing generator.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_CNT_W    = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } vga_ctl_t;

    // Half-open window test on a raster count: lo <= val < hi.
    function automatic logic in_range(logic [VGA_CNT_W-1:0] val, int unsigned lo, int unsigned hi);
        return (32'(val) >= lo) && (32'(val) < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Generic DEPTH-stage register shift line with synchronous reset to RESET_VALUE.
// DEPTH = 0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ reset_i;
            assign data_o = data_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VALUE;
                    end
                end else begin
                    stage_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign data_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter, sync/blank decode and pixel-alignment stage for the DVI display path.
// Define VGA_TEST_PATTERN_EN to add test_pattern_i and the x/y-derived colour pattern.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_FP        = VGA_H_FP,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_FP        = VGA_V_FP,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP,
    parameter bit          HSYNC_POL   = 1'b0,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned PIX_LATENCY = 2
) (
    input  logic       clk_pixel,
    input  logic       reset_i,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_pattern_i,
`endif
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       active_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    input  logic [3:0] vga_r_i,
    input  logic [3:0] vga_g_i,
    input  logic [3:0] vga_b_i,
    output logic       vga_hsync_o,
    output logic       vga_vsync_o,
    output logic       vga_blank_o,
    output logic [3:0] vga_r_o,
    output logic [3:0] vga_g_o,
    output logic [3:0] vga_b_o
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int          DLY      = int'(PIX_LATENCY);

    localparam vga_ctl_t CTL_IDLE = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, blank: 1'b1};

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit raster counters");
    end
    if (PIX_LATENCY > 7) begin : g_bad_latency
        $error("vga_timing_gen: PIX_LATENCY must be 0..7");
    end

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_last, v_last;
    logic       h_vis, v_vis;

    always_comb begin
        h_last  = (h_cnt_q == 10'(H_TOTAL - 1));
        v_last  = (v_cnt_q == 10'(V_TOTAL - 1));
        h_cnt_d = h_last ? '0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_vis         = 32'(h_cnt_q) < H_ACTIVE;
    assign v_vis         = 32'(v_cnt_q) < V_ACTIVE;
    assign x_o           = h_cnt_q;
    assign y_o           = v_cnt_q;
    assign active_o      = h_vis && v_vis;
    assign line_start_o  = (h_cnt_q == '0) && v_vis;
    assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);

    vga_ctl_t ctl_now, ctl_dly, ctl_q;

    always_comb begin
        ctl_now.hsync = in_range(h_cnt_q, HS_START, HS_START + H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        ctl_now.vsync = in_range(v_cnt_q, VS_START, VS_START + V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        ctl_now.blank = ~(h_vis && v_vis);
    end

    vga_delay_line #(
        .WIDTH       (3),
        .DEPTH       (DLY),
        .RESET_VALUE (CTL_IDLE)
    ) u_ctl_dly (
        .clk_i   (clk_pixel),
        .reset_i (reset_i),
        .data_i  (ctl_now),
        .data_o  (ctl_dly)
    );

    rgb444_t rgb_src, rgb_d, rgb_q;

`ifdef VGA_TEST_PATTERN_EN
    logic [19:0] xy_dly;
    logic [9:0]  x_dly, y_dly;

    // Coordinates ride the same latency as sync/blank so the pattern lines up.
    vga_delay_line #(
        .WIDTH       (20),
        .DEPTH       (DLY),
        .RESET_VALUE ('0)
    ) u_xy_dly (
        .clk_i   (clk_pixel),
        .reset_i (reset_i),
        .data_i  ({h_cnt_q, v_cnt_q}),
        .data_o  (xy_dly)
    );

    assign x_dly = xy_dly[19:10];
    assign y_dly = xy_dly[9:0];
`endif

    always_comb begin
        rgb_src = '{r: vga_r_i, g: vga_g_i, b: vga_b_i};
`ifdef VGA_TEST_PATTERN_EN
        if (test_pattern_i) begin
            rgb_src = '{r: x_dly[7:4], g: y_dly[7:4], b: x_dly[3:0] ^ y_dly[3:0]};
        end
`endif
        rgb_d = ctl_dly.blank ? '0 : rgb_src;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset_i) begin
            ctl_q <= CTL_IDLE;
            rgb_q <= '0;
        end else begin
            ctl_q <= ctl_dly;
            rgb_q <= rgb_d;
        end
    end

    assign vga_hsync_o = ctl_q.hsync;
    assign vga_vsync_o = ctl_q.vsync;
    assign vga_blank_o = ctl_q.blank;
    assign vga_r_o     = rgb_q.r;
    assign vga_g_o     = rgb_q.g;
    assign vga_b_o     = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a shrunken raster (latency 0, hsync active-high).
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst_m = 1'b1, rst_s = 1'b1;
    logic [3:0] r_m = '0, g_m = '0, b_m = '0;
    logic [3:0] r_s = 4'hF, g_s = 4'hF, b_s = 4'hF;
`ifdef VGA_TEST_PATTERN_EN
    logic       tp_m = 1'b0, tp_s = 1'b0;
`endif

    logic [9:0] x_m, y_m, x_s, y_s;
    logic       act_m, ls_m, fs_m, hs_m, vs_m, bl_m;
    logic       act_s, ls_s, fs_s, hs_s, vs_s, bl_s;
    logic [3:0] ro_m, go_m, bo_m, ro_s, go_s, bo_s;

    int n_checks = 0;
    int n_fail   = 0;
    int tm = 0;
    int ts = 0;

    vga_timing_gen dut_m (
        .clk_pixel     (clk),
        .reset_i       (rst_m),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern_i(tp_m),
`endif
        .x_o           (x_m),
        .y_o           (y_m),
        .active_o      (act_m),
        .line_start_o  (ls_m),
        .frame_start_o (fs_m),
        .vga_r_i       (r_m),
        .vga_g_i       (g_m),
        .vga_b_i       (b_m),
        .vga_hsync_o   (hs_m),
        .vga_vsync_o   (vs_m),
        .vga_blank_o   (bl_m),
        .vga_r_o       (ro_m),
        .vga_g_o       (go_m),
        .vga_b_o       (bo_m)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIX_LATENCY(0)
    ) dut_s (
        .clk_pixel     (clk),
        .reset_i       (rst_s),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern_i(tp_s),
`endif
        .x_o           (x_s),
        .y_o           (y_s),
        .active_o      (act_s),
        .line_start_o  (ls_s),
        .frame_start_o (fs_s),
        .vga_r_i       (r_s),
        .vga_g_i       (g_s),
        .vga_b_i       (b_s),
        .vga_hsync_o   (hs_s),
        .vga_vsync_o   (vs_s),
        .vga_blank_o   (bl_s),
        .vga_r_o       (ro_s),
        .vga_g_o       (go_s),
        .vga_b_o       (bo_s)
    );

    // Expected {x, y, active, line_start, frame_start} for counter cycle t.
    function automatic logic [22:0] exp_und(int t, int htot, int vtot, int hact, int vact);
        int hc = t % htot;
        int vc = (t / htot) % vtot;
        return {10'(hc), 10'(vc), (hc < hact) && (vc < vact), (hc == 0) && (vc < vact),
                (hc == 0) && (vc == 0)};
    endfunction

    // Expected {hsync, vsync, blank, r, g, b}; mode 0 = x/y/A data, 1 = constant F, 2 = test pattern.
    function automatic logic [14:0] exp_out(int t, int lat, int htot, int vtot, int hact, int vact,
                                            int hs0, int hs1, int vs0, int vs1,
                                            bit hpol, bit vpol, int mode);
        int         c = t - lat - 1;
        int         hc, vc;
        logic [9:0] h, v;
        logic       bl, hs, vs;
        logic [11:0] rgb;
        if (c < 0) return {~hpol, ~vpol, 1'b1, 12'h000};
        hc  = c % htot;
        vc  = (c / htot) % vtot;
        h   = 10'(hc);
        v   = 10'(vc);
        bl  = !((hc < hact) && (vc < vact));
        hs  = (hc >= hs0 && hc < hs1) ? hpol : ~hpol;
        vs  = (vc >= vs0 && vc < vs1) ? vpol : ~vpol;
        if (bl)             rgb = 12'h000;
        else if (mode == 2) rgb = {h[7:4], v[7:4], h[3:0] ^ v[3:0]};
        else if (mode == 1) rgb = 12'hFFF;
        else                rgb = {h[3:0], v[3:0], 4'hA};
        return {hs, vs, bl, rgb};
    endfunction

    task automatic tick_m();
        @(posedge clk);
        #1;
        tm++;
    endtask

    task automatic tick_s();
        @(posedge clk);
        #1;
        ts++;
    endtask

    // Fetch model: the pixel for counter cycle tm-2 is presented at cycle tm.
    task automatic drive_m(input int mode);
        int         c = (tm >= 2) ? tm - 2 : 0;
        logic [9:0] h = 10'(c % 800);
        logic [9:0] v = 10'((c / 800) % 525);
        if (mode == 0) begin
            r_m = h[3:0]; g_m = v[3:0]; b_m = 4'hA;
        end else begin
            r_m = 4'hF; g_m = 4'hF; b_m = 4'hF;
        end
    endtask

    task automatic do_reset_m(input int mode);
        rst_m = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_m = 1'b0;
        tm = 0;
        drive_m(mode);
    endtask

    task automatic test_reset();
        rst_m = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({x_m, y_m, fs_m, ls_m} !== {20'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_counters got x=%0d y=%0d fs=%b ls=%b exp x=0 y=0 fs=1 ls=1",
                     x_m, y_m, fs_m, ls_m);
        end
        n_checks++;
        if ({hs_m, vs_m, bl_m, ro_m, go_m, bo_m} !== 15'h7000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=7000", {hs_m, vs_m, bl_m, ro_m, go_m, bo_m});
        end
        rst_m = 1'b0;
        n_checks++;
        if ({fs_m, ls_m} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_first_cycle got fs=%b ls=%b exp fs=1 ls=1", fs_m, ls_m);
        end
    endtask

    task automatic test_align();
        logic [22:0] eu;
        logic [14:0] eo;
        int          hs_low = 0;
        do_reset_m(0);
        while (tm <= 5608) begin
            eu = exp_und(tm, 800, 525, 640, 480);
            eo = exp_out(tm, 2, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0, 1'b0, 0);
            n_checks++;
            if ({x_m, y_m, act_m, ls_m, fs_m} !== eu) begin
                n_fail++;
                $display("FAIL align_counters t=%0d got=%h exp=%h", tm, {x_m, y_m, act_m, ls_m, fs_m}, eu);
            end
            n_checks++;
            if ({hs_m, vs_m, bl_m, ro_m, go_m, bo_m} !== eo) begin
                n_fail++;
                $display("FAIL align_out t=%0d got=%h exp=%h", tm, {hs_m, vs_m, bl_m, ro_m, go_m, bo_m}, eo);
            end
            if (tm >= 803 && tm < 1603 && hs_m == 1'b0) hs_low++;
            if (tm == 5608) break;
            tick_m();
            drive_m(0);
        end
        n_checks++;
        if ({bl_m, ro_m, go_m, bo_m} !== 13'h057A) begin
            n_fail++;
            $display("FAIL align_pixel_5_7 got blank=%b rgb=%h exp blank=0 rgb=57a", bl_m, {ro_m, go_m, bo_m});
        end
        n_checks++;
        if (hs_low !== 96) begin
            n_fail++;
            $display("FAIL hsync_low_width got=%0d exp=96", hs_low);
        end
    endtask

    task automatic test_blank_reset();
        logic [14:0] eo;
        do_reset_m(1);
        while (tm <= 2700) begin
            eo = exp_out(tm, 2, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0, 1'b0, 1);
            n_checks++;
            if ({hs_m, vs_m, bl_m, ro_m, go_m, bo_m} !== eo) begin
                n_fail++;
                $display("FAIL blank_out t=%0d got=%h exp=%h", tm, {hs_m, vs_m, bl_m, ro_m, go_m, bo_m}, eo);
            end
            if (tm == 2700) break;
            tick_m();
            drive_m(1);
        end
        n_checks++;
        if ({x_m, y_m} !== {10'd300, 10'd3}) begin
            n_fail++;
            $display("FAIL midframe_position got x=%0d y=%0d exp x=300 y=3", x_m, y_m);
        end
        rst_m = 1'b1;
        tick_m();
        rst_m = 1'b0;
        tm = 0;
        n_checks++;
        if ({x_m, y_m, fs_m} !== {20'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL midframe_restart got x=%0d y=%0d fs=%b exp x=0 y=0 fs=1", x_m, y_m, fs_m);
        end
        for (int i = 0; i < 5; i++) begin
            eo = exp_out(tm, 2, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0, 1'b0, 1);
            n_checks++;
            if ({hs_m, vs_m, bl_m, ro_m, go_m, bo_m} !== eo) begin
                n_fail++;
                $display("FAIL midframe_out t=%0d got=%h exp=%h", tm, {hs_m, vs_m, bl_m, ro_m, go_m, bo_m}, eo);
            end
            tick_m();
            drive_m(1);
        end
    endtask

    task automatic test_small_raster();
        logic [22:0] eu;
        logic [14:0] eo;
        int hs_high = 0, vs_low = 0, fs_cnt = 0, fs_last = -1;
        rst_s = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_s = 1'b0;
        ts = 0;
        while (ts <= 480) begin
            eu = exp_und(ts, 24, 10, 16, 6);
            eo = exp_out(ts, 0, 24, 10, 16, 6, 18, 21, 7, 9, 1'b1, 1'b0, 1);
            n_checks++;
            if ({x_s, y_s, act_s, ls_s, fs_s} !== eu) begin
                n_fail++;
                $display("FAIL small_counters t=%0d got=%h exp=%h", ts, {x_s, y_s, act_s, ls_s, fs_s}, eu);
            end
            n_checks++;
            if ({hs_s, vs_s, bl_s, ro_s, go_s, bo_s} !== eo) begin
                n_fail++;
                $display("FAIL small_out t=%0d got=%h exp=%h", ts, {hs_s, vs_s, bl_s, ro_s, go_s, bo_s}, eo);
            end
            if (ts >= 1 && hs_s == 1'b1) hs_high++;
            if (ts >= 1 && vs_s == 1'b0) vs_low++;
            if (fs_s == 1'b1) begin
                if (fs_last >= 0) begin
                    n_checks++;
                    if (ts - fs_last !== 240) begin
                        n_fail++;
                        $display("FAIL frame_period got=%0d exp=240", ts - fs_last);
                    end
                end
                fs_last = ts;
                fs_cnt++;
            end
            if (ts == 480) break;
            tick_s();
        end
        n_checks++;
        if (hs_high !== 60) begin
            n_fail++;
            $display("FAIL small_hsync_high got=%0d exp=60", hs_high);
        end
        n_checks++;
        if (vs_low !== 96) begin
            n_fail++;
            $display("FAIL small_vsync_low got=%0d exp=96", vs_low);
        end
        n_checks++;
        if (fs_cnt !== 3) begin
            n_fail++;
            $display("FAIL frame_start_count got=%0d exp=3", fs_cnt);
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [14:0] eo;
        tp_m = 1'b1;
        do_reset_m(1);
        while (tm <= 35256) begin
            eo = exp_out(tm, 2, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0, 1'b0, 2);
            n_checks++;
            if ({hs_m, vs_m, bl_m, ro_m, go_m, bo_m} !== eo) begin
                n_fail++;
                $display("FAIL pattern_out t=%0d got=%h exp=%h", tm, {hs_m, vs_m, bl_m, ro_m, go_m, bo_m}, eo);
            end
            if (tm == 35256) break;
            tick_m();
            drive_m(1);
        end
        n_checks++;
        if ({bl_m, ro_m, go_m, bo_m} !== 13'h0329) begin
            n_fail++;
            $display("FAIL pattern_pixel_35_2c got blank=%b rgb=%h exp blank=0 rgb=329", bl_m, {ro_m, go_m, bo_m});
        end
        tp_m = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_align();
        test_blank_reset();
        test_small_raster();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
